// File: rtl/btn_event_arbiter.sv
// Latches button rising edges per input and serialises them round-robin onto one valid/ready event stream.
// Two cycles from edge to evt_valid; evt_valid/evt_id hold while evt_ready is low, then one event per cycle.
module btn_event_arbiter #(
  parameter int N_INPUTS = 4,
  parameter int ID_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] btn_in,
  input  logic [N_INPUTS-1:0] enable_mask,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [ID_W-1:0]     evt_id,
  output logic [N_INPUTS-1:0] overrun,
  input  logic                overrun_clr
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state;
  logic [N_INPUTS-1:0] prev;
  logic [N_INPUTS-1:0] pending;
  logic [ID_W-1:0]     rr_ptr;

  logic [N_INPUTS-1:0] edge_det;
  logic [N_INPUTS-1:0] eligible;
  logic [N_INPUTS-1:0] grant_oh;
  logic [N_INPUTS-1:0] ovr_set;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     hi_idx;
  logic [ID_W-1:0]     lo_idx;
  logic [ID_W-1:0]     next_rr;
  logic                hi_hit;
  logic                do_grant;

  assign edge_det = btn_in & ~prev;
  // A pending bit whose mask has dropped is no longer a grant candidate.
  assign eligible = pending & enable_mask;

  // Descending scan: the last hit is the lowest index, both at/above rr_ptr and overall.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = ID_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_hit = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
  end

  assign grant_idx = hi_hit ? hi_idx : lo_idx;
  assign do_grant  = (|eligible) && (!evt_valid || evt_ready);
  assign next_rr   = (grant_idx == ID_W'(N_INPUTS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      grant_oh[i] = do_grant && (grant_idx == ID_W'(i));
    end
  end

  assign ovr_set = edge_det & enable_mask & pending & ~grant_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      overrun   <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      prev    <= btn_in;
      pending <= enable_mask & ((pending & ~grant_oh) | edge_det);
      overrun <= (overrun & ~{N_INPUTS{overrun_clr}}) | ovr_set;
      case (state)
        IDLE: begin
          if (do_grant) begin
            state     <= HOLD;
            evt_valid <= 1'b1;
            evt_id    <= grant_idx;
            rr_ptr    <= next_rr;
          end
        end
        HOLD: begin
          if (evt_ready) begin
            if (do_grant) begin
              evt_id <= grant_idx;
              rr_ptr <= next_rr;
            end else begin
              state     <= IDLE;
              evt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: event-level model compared every cycle plus literal sequence checks.
module tb_btn_event_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] enable_mask;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic [N-1:0] overrun;
  logic         overrun_clr;

  int checks = 0;
  int failures = 0;
  int acc[$];

  bit [N-1:0] m_prev, m_pend, m_over;
  bit         m_valid;
  int         m_id, m_rr;

  btn_event_arbiter #(.N_INPUTS(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .enable_mask(enable_mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  // Model: per-input pending flags, a rotating search start and one output slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = '0; m_pend = '0; m_over = '0; m_valid = 0; m_id = 0; m_rr = 0;
    end else begin
      int gi;
      bit e;
      bit [N-1:0] np;
      gi = -1;
      np = '0;
      if (!m_valid || evt_ready) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (gi < 0 && m_pend[j] && enable_mask[j]) gi = j;
        end
      end
      for (int i = 0; i < N; i++) begin
        e = btn_in[i] && !m_prev[i];
        if (e && enable_mask[i] && m_pend[i] && i != gi) m_over[i] = 1;
        else if (overrun_clr) m_over[i] = 0;
        np[i] = enable_mask[i] && ((m_pend[i] && i != gi) || e);
      end
      m_pend = np;
      m_prev = btn_in;
      if (gi >= 0) begin
        m_valid = 1; m_id = gi; m_rr = (gi + 1) % N;
      end else if (m_valid && evt_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (evt_valid !== m_valid) begin
        failures++;
        $display("FAIL model_valid t=%0t: got %0b expected %0b", $time, evt_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (int'(evt_id) != m_id) begin
          failures++;
          $display("FAIL model_id t=%0t: got %0d expected %0d", $time, evt_id, m_id);
        end
      end
      checks++;
      if (overrun !== m_over) begin
        failures++;
        $display("FAIL model_overrun t=%0t: got %b expected %b", $time, overrun, m_over);
      end
      if (evt_valid && evt_ready) acc.push_back(int'(evt_id));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input int n, input int e0, input int e1,
                         input int e2, input int e3, input int e4);
    int exp[5];
    exp = '{e0, e1, e2, e3, e4};
    chk({name, "_len"}, acc.size(), n);
    for (int i = 0; i < n && i < acc.size(); i++) chk($sformatf("%s_%0d", name, i), acc[i], exp[i]);
  endtask

  task automatic do_reset();
    btn_in = '0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; btn_in = '0; enable_mask = 4'b1111; evt_ready = 1'b0; overrun_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_id", int'(evt_id), 0);
    chk("reset_overrun", int'(overrun), 0);

    // Single press: pending after edge k, presented after k+1 for one cycle.
    evt_ready = 1'b1;
    btn_in = 4'b0100;
    tick(1);
    chk("single_not_yet", int'(evt_valid), 0);
    tick(1);
    chk("single_valid", int'(evt_valid), 1);
    chk("single_id", int'(evt_id), 2);
    tick(1);
    chk("single_drop", int'(evt_valid), 0);
    tick(4);
    chk_seq("single_seq", 1, 2, 0, 0, 0, 0);

    // Fairness from rr_ptr=0, then from rr_ptr=2.
    do_reset();
    acc.delete();
    btn_in = 4'b1111;
    tick(7);
    chk_seq("fair0", 4, 0, 1, 2, 3, 0);
    btn_in = '0; tick(1);
    btn_in = 4'b0010; tick(4);
    btn_in = '0; tick(1);
    acc.delete();
    btn_in = 4'b1111;
    tick(7);
    chk_seq("fair2", 4, 2, 3, 0, 1, 0);

    // Backpressure and overrun.
    evt_ready = 1'b0; btn_in = '0; tick(1);
    acc.delete();
    btn_in = 4'b0010; tick(2);
    chk("bp_valid", int'(evt_valid), 1);
    chk("bp_id1", int'(evt_id), 1);
    btn_in = 4'b1010; tick(1);
    btn_in = 4'b0010; tick(1);
    btn_in = 4'b1010; tick(1);
    chk("bp_overrun", int'(overrun), 8);
    chk("bp_id_held", int'(evt_id), 1);
    evt_ready = 1'b1; tick(1);
    chk("bp_id3", int'(evt_id), 3);
    tick(1);
    chk("bp_idle", int'(evt_valid), 0);
    overrun_clr = 1'b1; tick(1);
    overrun_clr = 1'b0;
    chk("bp_clr", int'(overrun), 0);
    chk_seq("bp_seq", 2, 1, 3, 0, 0, 0);
    btn_in = '0; tick(1);

    // Masking: masked edge ignored; pending dropped when mask clears before grant.
    acc.delete();
    enable_mask = 4'b1110;
    btn_in = 4'b0001; tick(3);
    btn_in = '0; tick(1);
    btn_in = 4'b0010; tick(1);
    enable_mask = 4'b1100; tick(3);
    enable_mask = 4'b1111; tick(2);
    chk("mask_events", acc.size(), 0);
    btn_in = '0; tick(1);

    // Collision: new edge on input 2 while its pending bit is granted.
    evt_ready = 1'b0;
    acc.delete();
    btn_in = 4'b0010; tick(2);
    btn_in = 4'b0110; tick(1);
    btn_in = 4'b0010; tick(1);
    btn_in = 4'b0110; evt_ready = 1'b1; tick(4);
    chk_seq("coll_seq", 3, 1, 2, 2, 0, 0);
    chk("coll_overrun", int'(overrun), 0);

    // Asynchronous reset mid-HOLD, input 0 held high through release.
    btn_in = '0; evt_ready = 1'b0; tick(1);
    acc.delete();
    btn_in = 4'b0001; tick(2);
    chk("ar_valid_before", int'(evt_valid), 1);
    #1 rst_n = 1'b0;
    #1 chk("ar_valid_async", int'(evt_valid), 0);
    tick(1);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    tick(5);
    chk_seq("ar_seq", 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects rising-edge events from up to N conditioned button inputs (outputs of the per-button input-conditioning blocks) and serialises them into a single valid/ready event stream carrying the button index. Each input has a one-deep pending latch. A round-robin pointer shares the single output slot fairly among inputs. It sits between the board input-conditioning stage and the game/control FSM, which consumes one button event at a time.

## Interface
- N_INPUTS, 4: number of button inputs, 2..16.
- ID_W, 2: width of event index; N_INPUTS <= 2**ID_W.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- btn_in  input  N_INPUTS  conditioned button levels, already synchronous to clk.
- enable_mask  input  N_INPUTS  1 = input may generate events.
- evt_valid  output  1  event presented on evt_id.
- evt_ready  input  1  consumer accepts event when high with evt_valid.
- evt_id  output  ID_W  index of button that produced the presented event.
- overrun  output  N_INPUTS  sticky: an edge arrived while that input was already pending.
- overrun_clr  input  1  clears all overrun bits.

## Operation
- Reset values: evt_valid=0, evt_id=0, overrun=0, pending=0, prev=0, rr_ptr=0, FSM=IDLE.
- Edge detect: edge[i] = btn_in[i] & ~prev[i]; prev[i] <= btn_in[i] every cycle regardless of mask.
  - prev resets to 0, so an input held high through reset release yields exactly one event.
- Pending: on edge[i] & enable_mask[i], pending[i] <= 1.
  - If pending[i] is already 1 and not being granted this cycle, set overrun[i]; the event is dropped.
- Mask: enable_mask[i]=0 clears pending[i] next edge. Edges are ignored while masked. An event already on evt_id is unaffected.
- FSM states:
  - IDLE: evt_valid=0. If any pending, grant → HOLD.
  - HOLD: evt_valid=1, evt_id stable. On evt_valid & evt_ready:
    - if any pending (excluding the granted bit's new edge this cycle is fine, see below), grant again and stay HOLD;
    - else → IDLE.
- Grant: select the first pending index scanning rr_ptr, rr_ptr+1, … wrapping at N_INPUTS-1 → 0.
  - evt_id <= index; pending[index] <= 0; rr_ptr <= index+1, or 0 if index = N_INPUTS-1.
- Simultaneous events:
  - Edge on input i in the same cycle pending[i] is granted: pending[i] stays 1 (new event), no overrun.
  - Edge on the input currently presented on evt_id: sets pending normally, no overrun.
  - overrun set and overrun_clr in the same cycle: set wins for that bit; other bits clear.
- evt_id and evt_valid do not change in HOLD until accepted; the consumer may stall indefinitely.
- Reset asserted mid-operation: all state returns to reset values immediately; pending events are lost.

## Timing
- Latency: btn_in rises before clk edge k → pending after edge k → evt_valid=1 after edge k+1 (2 cycles).
- Throughput: with evt_ready held high and events pending, one event accepted per cycle. evt_valid stays high across back-to-back grants.
- Pending sampled for grant is the registered value (an edge at edge k cannot be granted at edge k).
- overrun visible the cycle after the offending edge; cleared the cycle after overrun_clr.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold btn_in=0, rst_n=0 then release → evt_valid=0, overrun=0; assert rst_n=0 asynchronously mid-HOLD → evt_valid drops without a clock edge.
- Single press: btn_in[2] 0→1 before edge k, evt_ready=1 → evt_valid=1 with evt_id=2 after edge k+1 for exactly one cycle; holding btn_in[2] high produces no further events.
- Fairness: btn_in=4'b1111 rising together, evt_ready=1, rr_ptr=0 → evt_id sequence 0,1,2,3 on consecutive cycles; then repeat from rr_ptr=2 → 2,3,0,1.
- Backpressure and overrun: evt_ready=0, press btn 1 → evt_id=1 held; press btn 3 twice → pending[3]=1, overrun=4'b1000; evt_ready=1 → evt_id=3 next; overrun_clr → overrun=0.
- Masking: enable_mask=4'b1110, press btn 0 → no event; press btn 1 then clear mask bit 1 before grant → no event.
- Collision: edge on btn 2 in the same cycle pending[2] is granted → second evt_id=2 event follows, overrun stays 0.
